// File: rtl/cpu_alu.sv
// ============================================================================
// Module   : cpu_alu
// Brief    : 8-bit 6502-style ALU (ADD/SUB/AND/OR/EOR/SR, N/V/Z/C flags)
//            with a registered flag snapshot. Optional BCD add/subtract is
//            enabled by defining the macro ALU_DECIMAL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [4:0]       mode,
  input  logic             carry_in,
  input  logic             decimal,
  input  logic             flag_we,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             sign,
  output logic [3:0]       flags_q
);

  localparam logic [4:0] c_MODE_ADD = 5'd0;
  localparam logic [4:0] c_MODE_AND = 5'd1;
  localparam logic [4:0] c_MODE_OR  = 5'd2;
  localparam logic [4:0] c_MODE_EOR = 5'd3;
  localparam logic [4:0] c_MODE_SR  = 5'd4;
  localparam logic [4:0] c_MODE_SUB = 5'd5;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_out;
  logic             w_c;
  logic             w_v;
  logic             w_dec_add;
  logic             w_dec_sub;
  logic [WIDTH-1:0] r_unused_dummy_n;

  assign w_add = {1'b0, alu_a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, carry_in};
  assign w_sub = {1'b0, alu_a} + {1'b0, ~alu_b} + {{WIDTH{1'b0}}, carry_in};

`ifdef ALU_DECIMAL_EN
  // Nibble sums are 6 bits wide so non-BCD operands cannot wrap the adjust.
  logic [5:0]       w_dlo;
  logic [5:0]       w_dhi;
  logic             w_dhi_c;
  logic [4:0]       w_slo;
  logic [WIDTH-1:0] w_dadd_out;
  logic [WIDTH-1:0] w_dsub_out;

  always_comb begin
    w_dlo = {2'b00, alu_a[3:0]} + {2'b00, alu_b[3:0]} + {5'd0, carry_in};
    if (w_dlo > 6'd9) w_dlo = w_dlo + 6'd6;
    w_dhi = {2'b00, alu_a[7:4]} + {2'b00, alu_b[7:4]} + {5'd0, (w_dlo > 6'd15)};
    w_dhi_c = (w_dhi > 6'd9);
    if (w_dhi_c) w_dhi = w_dhi + 6'd6;
    w_dadd_out = {w_dhi[3:0], w_dlo[3:0]};
    w_slo = {1'b0, alu_a[3:0]} + {1'b0, ~alu_b[3:0]} + {4'd0, carry_in};
    w_dsub_out = w_sub[WIDTH-1:0]
               - (w_slo[4] ? 8'h00 : 8'h06)
               - (w_sub[WIDTH] ? 8'h00 : 8'h60);
  end

  assign w_dec_add = decimal && (mode == c_MODE_ADD);
  assign w_dec_sub = decimal && (mode == c_MODE_SUB);
`else
  logic w_unused_decimal;
  assign w_unused_decimal = decimal;
  assign w_dec_add = 1'b0;
  assign w_dec_sub = 1'b0;
`endif

  always_comb begin
    w_out = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (mode)
      c_MODE_ADD: begin
        w_out = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (w_add[WIDTH-1] != alu_a[WIDTH-1]);
      end
      c_MODE_SUB: begin
        w_out = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (w_sub[WIDTH-1] != alu_a[WIDTH-1]);
      end
      c_MODE_AND: w_out = alu_a & alu_b;
      c_MODE_OR:  w_out = alu_a | alu_b;
      c_MODE_EOR: w_out = alu_a ^ alu_b;
      c_MODE_SR: begin
        w_out = {carry_in, alu_a[WIDTH-1:1]};
        w_c   = alu_a[0];
      end
      default: ;
    endcase
`ifdef ALU_DECIMAL_EN
    // Overflow stays on the binary result; only value and carry are adjusted.
    if (w_dec_add) begin
      w_out = w_dadd_out;
      w_c   = w_dhi_c;
    end else if (w_dec_sub) begin
      w_out = w_dsub_out;
    end
`endif
  end

  assign alu_out   = w_out;
  assign carry_out = w_c;
  assign overflow  = w_v;
  assign zero      = (w_out == '0);
  assign sign      = w_out[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (flag_we) begin
      flags_q <= {sign, overflow, zero, carry_out};
    end
  end

  // Keeps the decimal-select wires referenced in the binary-only build.
  always_comb begin
    r_unused_dummy_n = '0;
    if (w_dec_add || w_dec_sub) r_unused_dummy_n = '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_alu.sv
// ============================================================================
// Module   : tb_cpu_alu
// Brief    : Self-checking bench for cpu_alu: directed cases plus randomized
//            operations compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_alu;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] alu_a, alu_b;
  logic [4:0] mode;
  logic       carry_in, decimal, flag_we;
  logic [7:0] alu_out;
  logic       carry_out, overflow, zero, sign;
  logic [3:0] flags_q;

  int n_total = 0;
  int n_pass  = 0;

  cpu_alu #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .alu_a(alu_a), .alu_b(alu_b), .mode(mode),
    .carry_in(carry_in), .decimal(decimal), .flag_we(flag_we),
    .alu_out(alu_out), .carry_out(carry_out), .overflow(overflow),
    .zero(zero), .sign(sign), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  function automatic int sval(input int u);
    return (u > 127) ? u - 256 : u;
  endfunction

  // Reference: returns {c, v, out[7:0]} computed from integer arithmetic.
  function automatic logic [9:0] model(input int m, input int a, input int b,
                                       input int ci, input int dec);
    int r, c, v, s, lo, hi;
    r = 0; c = 0; v = 0;
    if (m == 0) begin
      s = a + b + ci;
      r = s % 256; c = (s > 255) ? 1 : 0;
      s = sval(a) + sval(b) + ci;
      v = (s > 127 || s < -128) ? 1 : 0;
`ifdef ALU_DECIMAL_EN
      if (dec != 0) begin
        lo = a % 16 + b % 16 + ci;
        if (lo > 9) lo = lo + 6;
        hi = a / 16 + b / 16 + ((lo > 15) ? 1 : 0);
        c = (hi > 9) ? 1 : 0;
        if (c != 0) hi = hi + 6;
        r = (hi % 16) * 16 + lo % 16;
      end
`endif
    end else if (m == 5) begin
      s = a - b - (1 - ci);
      c = (s >= 0) ? 1 : 0;
      r = (s + 256) % 256;
      s = sval(a) - sval(b) - (1 - ci);
      v = (s > 127 || s < -128) ? 1 : 0;
`ifdef ALU_DECIMAL_EN
      if (dec != 0) begin
        lo = a % 16 - b % 16 - (1 - ci);
        if (lo < 0) r = r - 6;
        if (c == 0) r = r - 96;
        r = (r + 512) % 256;
      end
`endif
    end else if (m == 1) r = a & b;
    else if (m == 2) r = a | b;
    else if (m == 3) r = a ^ b;
    else if (m == 4) begin
      r = ci * 128 + a / 2; c = a % 2;
    end
    return {c[0], v[0], r[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  // Drives one operation and checks every combinational output against the model.
  task automatic op(input string tag, input int m, input int a, input int b,
                    input int ci, input int dec);
    logic [9:0] e;
    mode = m[4:0]; alu_a = a[7:0]; alu_b = b[7:0];
    carry_in = ci[0]; decimal = dec[0];
    #1;
    e = model(m, a, b, ci, dec);
    chk({tag, ".out"}, alu_out, e[7:0]);
    chk({tag, ".c"}, {7'd0, carry_out}, {7'd0, e[9]});
    chk({tag, ".v"}, {7'd0, overflow}, {7'd0, e[8]});
    chk({tag, ".z"}, {7'd0, zero}, {7'd0, (e[7:0] == 8'd0)});
    chk({tag, ".n"}, {7'd0, sign}, {7'd0, e[7]});
  endtask

  initial begin
    logic [3:0] exp_flags;
    logic [9:0] e;
    int m;
    reset = 1'b1; flag_we = 1'b0; mode = 5'd0; alu_a = 8'd0; alu_b = 8'd0;
    carry_in = 1'b0; decimal = 1'b0;

    // Flag register: reset on one edge
    @(negedge clk);
    op("add_ff_01", 0, 8'hFF, 8'h01, 0, 0);
    @(posedge clk); #1;
    chk("flags_reset", {4'd0, flags_q}, 8'h00);

    @(negedge clk); reset = 1'b0; flag_we = 1'b1;
    @(posedge clk); #1;
    chk("flags_capture", {4'd0, flags_q}, 8'h03);

    @(negedge clk); flag_we = 1'b0;
    op("add_50_50", 0, 8'h50, 8'h50, 0, 0);
    chk("add_50_50.out_direct", alu_out, 8'hA0);
    @(posedge clk); #1;
    chk("flags_hold", {4'd0, flags_q}, 8'h03);

    @(negedge clk); flag_we = 1'b1;
    @(posedge clk); #1;
    chk("flags_capture2", {4'd0, flags_q}, 8'h0C);

    @(negedge clk); reset = 1'b1; flag_we = 1'b1;
    @(posedge clk); #1;
    chk("flags_reset_prio", {4'd0, flags_q}, 8'h00);
    @(negedge clk); reset = 1'b0; flag_we = 1'b0;

    // Directed datapath cases
    op("add_ff_01b", 0, 8'hFF, 8'h01, 0, 0);
    chk("add_ff_01.out_direct", alu_out, 8'h00);
    op("sub_05_03", 5, 8'h05, 8'h03, 1, 0);
    chk("sub_05_03.out_direct", alu_out, 8'h02);
    op("sub_00_01", 5, 8'h00, 8'h01, 1, 0);
    chk("sub_00_01.out_direct", alu_out, 8'hFF);
    op("sub_80_01", 5, 8'h80, 8'h01, 1, 0);
    chk("sub_80_01.v_direct", {7'd0, overflow}, 8'h01);
    op("and", 1, 8'hF0, 8'h3C, 1, 0);
    chk("and.out_direct", alu_out, 8'h30);
    op("or", 2, 8'hF0, 8'h3C, 1, 0);
    op("eor", 3, 8'hF0, 8'h3C, 1, 0);
    op("sr_81", 4, 8'h81, 8'h55, 0, 0);
    chk("sr_81.out_direct", alu_out, 8'h40);
    op("sr_02", 4, 8'h02, 8'hAA, 1, 0);
    chk("sr_02.out_direct", alu_out, 8'h81);
    op("rsv7", 7, 8'h12, 8'h34, 1, 0);
    op("rsv31", 31, 8'hFF, 8'hFF, 1, 1);
    op("logic_dec_ignored", 2, 8'h0F, 8'h90, 0, 1);

`ifdef ALU_DECIMAL_EN
    op("dadd_09_01", 0, 8'h09, 8'h01, 0, 1);
    chk("dadd_09_01.out_direct", alu_out, 8'h10);
    op("dadd_99_01", 0, 8'h99, 8'h01, 0, 1);
    chk("dadd_99_01.out_direct", alu_out, 8'h00);
    op("dsub_10_01", 5, 8'h10, 8'h01, 1, 1);
    chk("dsub_10_01.out_direct", alu_out, 8'h09);
`else
    op("bin_add_dec_ignored", 0, 8'h09, 8'h01, 0, 1);
    chk("bin_add_dec.out_direct", alu_out, 8'h0A);
`endif

    // Randomized operations with a modelled flag register
    exp_flags = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      m = ($urandom % 5 == 0) ? int'($urandom_range(6, 31)) : int'($urandom_range(0, 5));
      flag_we = $urandom_range(0, 1);
      op("rand", m, $urandom % 256, $urandom % 256, $urandom % 2, $urandom % 2);
      e = model(m, alu_a, alu_b, carry_in, decimal);
      if (flag_we) exp_flags = {e[7], e[8], (e[7:0] == 8'd0), e[9]};
      @(posedge clk); #1;
      chk("rand_flags", {4'd0, flags_q}, {4'd0, exp_flags});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/cpu_alu.md
Name: cpu_alu

Overview:
- 8-bit ALU for the 6502-compatible CPU core.
- Combinational datapath: add/subtract with carry, AND, OR, EOR and shift-right, with N/V/Z/C flag generation.
- Also holds a small registered flag snapshot, so the controller can sample flags one cycle after an operation.
- Result outputs are combinational: the controller uses `alu_out` in the same cycle for address arithmetic.

Parameters:
- WIDTH, 8, datapath width. Only 8 is supported. Flag bit positions refer to bit WIDTH-1.

Ports:
- clk        input   1  system clock, rising edge
- reset      input   1  synchronous, active-high reset
- alu_a      input   8  operand A
- alu_b      input   8  operand B
- mode       input   5  operation select: 0 ADD, 1 AND, 2 OR, 3 EOR, 4 SR, 5 SUB, 6-31 reserved
- carry_in   input   1  carry in. For SUB it means "no borrow". For SR it is the bit shifted into bit 7.
- decimal    input   1  BCD request. Used only with ALU_DECIMAL_EN; otherwise ignored.
- flag_we    input   1  capture the current flags into `flags_q` at the next clock edge
- alu_out    output  8  result (combinational)
- carry_out  output  1  carry / not-borrow / shifted-out bit (combinational)
- overflow   output  1  signed overflow (combinational)
- zero       output  1  high when alu_out == 0 (combinational)
- sign       output  1  alu_out[7] (combinational)
- flags_q    output  4  registered {sign, overflow, zero, carry_out}

Behaviour:
- ADD (mode 0):
  - {carry_out, alu_out} = alu_a + alu_b + carry_in, computed 9 bits wide.
  - overflow = (a7 == b7) and (out7 != a7).
- SUB (mode 5):
  - Computed as alu_a + ~alu_b + carry_in, 9 bits wide.
  - carry_out = 1 means no borrow.
  - overflow = (a7 != b7) and (out7 != a7).
- AND / OR / EOR (modes 1/2/3):
  - Bitwise operation of alu_a and alu_b.
  - carry_out = 0, overflow = 0.
- SR (mode 4):
  - alu_out = {carry_in, alu_a[7:1]}; carry_out = alu_a[0]; overflow = 0.
  - alu_b is ignored.
  - carry_in = 0 gives LSR; carry_in = 1 gives ROR with C set.
- Reserved modes 6-31:
  - alu_out = 0, carry_out = 0, overflow = 0.
  - zero = 1 and sign = 0 follow from the zero result.
- zero and sign always derive from the final alu_out, in every mode.
- All combinational outputs settle within the same cycle as the inputs. No latency; no internal state affects them.
- flags_q:
  - On a rising edge with reset = 1, flags_q becomes 4'b0000. Reset takes priority over flag_we.
  - Otherwise, if flag_we = 1, flags_q captures {sign, overflow, zero, carry_out} as present before the edge.
  - Otherwise flags_q holds.
  - Reset value of flags_q is 0. The combinational outputs have no reset dependence.
- Wrap-around: results are modulo 256.
  - 0xFF + 0x01 + 0 gives 0x00 with C = 1, Z = 1.
  - 0x00 - 0x01 with carry_in = 1 gives 0xFF with C = 0, N = 1.
- The block does not depend on X/Y/A registers. Operand muxing is the controller's job.

Optional Feature:
- Macro: ALU_DECIMAL_EN.
- Defined, and decimal = 1 with mode ADD:
  - Low nibble: if (a_lo + b_lo + cin) > 9, add 6 and carry into the high nibble.
  - High nibble: if the adjusted high sum > 9, add 0x60 and set carry_out = 1.
- Defined, and decimal = 1 with mode SUB:
  - Perform the binary subtract; carry_out is taken from the binary result.
  - Subtract 6 if the low nibble borrowed; subtract 0x60 if carry_out = 0.
- Decimal-mode flags:
  - zero and sign come from the adjusted alu_out.
  - overflow comes from the binary (unadjusted) sum.
- Other modes ignore decimal.
- Not defined: the decimal port is present but ignored; all modes are pure binary.

Test Plan:
- ADD: a = 0x50, b = 0x50, cin = 0 -> out 0xA0, C = 0, V = 1, N = 1, Z = 0. Then a = 0xFF, b = 0x01, cin = 0 -> out 0x00, C = 1, Z = 1, V = 0.
- SUB: a = 0x05, b = 0x03, cin = 1 -> out 0x02, C = 1. Then a = 0x00, b = 0x01, cin = 1 -> out 0xFF, C = 0, N = 1. Then a = 0x80, b = 0x01, cin = 1 -> out 0x7F, V = 1.
- Logic: a = 0xF0, b = 0x3C -> AND 0x30, OR 0xFC, EOR 0xCC; C = 0, V = 0 for all three.
- SR: a = 0x81, cin = 0 -> out 0x40, C = 1. Then a = 0x02, cin = 1 -> out 0x81, C = 0, N = 1. Reserved mode 7 -> out 0x00, Z = 1.
- Flag register: reset = 1 for one edge -> flags_q = 0. ADD 0xFF + 0x01 with flag_we = 1 -> flags_q = 4'b0011 next cycle. flag_we = 0 -> flags_q holds. reset asserted together with flag_we = 1 -> flags_q = 0.
- With ALU_DECIMAL_EN, decimal = 1:
  - ADD 0x09 + 0x01, cin = 0 -> 0x10, C = 0.
  - ADD 0x99 + 0x01 -> 0x00, C = 1, Z = 1.
  - SUB 0x10 - 0x01, cin = 1 -> 0x09, C = 1.
